// File: rtl/scpu_pkg.sv
// Shared scpu types: sequencer states, writeback source and CSR op codes.
// Imported by the sequencer and by the instruction decoder.
package scpu_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IF_REQ,
    S_IF_WAIT,
    S_EX,
    S_LS_REQ,
    S_LS_WAIT,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [2:0] WD_SRC_MEM = 3'b100;

  localparam logic [2:0] CSR_ECALL = 3'b010;
  localparam logic [2:0] CSR_MRET  = 3'b011;
  localparam logic [2:0] CSR_RW    = 3'b101;
  localparam logic [2:0] CSR_RS    = 3'b110;

  function automatic logic csr_writes(input logic [2:0] op);
    logic w;
    w = 1'b0;
    unique case (op)
      CSR_ECALL, CSR_MRET,
      CSR_RW, CSR_RS: w = 1'b1;
      default:        w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Loadable down-counter: reloads on clear, decrements while enabled,
// flags expiry once CYCLES-1 enabled cycles have elapsed since the clear.
module seq_timeout #(
  parameter int CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer between the decoder and the IFU/LSU
// bus masters; gates pc/regfile/csr writes to one cycle per instruction.
module exec_sequencer
  import scpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int COUNTER_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req_valid,
  input  logic                 ifu_req_ready,
  input  logic                 ifu_rsp_valid,
  input  logic                 ifu_rsp_err,
  output logic                 inst_we,
  input  logic                 dec_reg_write,
  input  logic                 dec_mem_write,
  input  logic [2:0]           dec_wd_src,
  input  logic [2:0]           dec_csr,
  output logic                 lsu_req_valid,
  input  logic                 lsu_req_ready,
  output logic                 lsu_req_wen,
  input  logic                 lsu_rsp_valid,
  input  logic                 lsu_rsp_err,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 csr_we,
  output logic                 trap,
  output logic [COUNTER_W-1:0] minstret
);

  state_t               state_q, state_d;
  logic [COUNTER_W-1:0] minstret_q, minstret_d;
  logic                 tmo_exp, tmo_en, tmo_clr;
  logic                 is_mem;

  assign is_mem = dec_mem_write | (dec_wd_src == WD_SRC_MEM);

  assign tmo_en  = state_q inside {S_IF_REQ, S_IF_WAIT,
                                   S_LS_REQ, S_LS_WAIT};
  assign tmo_clr = (state_d != state_q);

  seq_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_exp)
  );

  always_comb begin
    state_d       = state_q;
    minstret_d    = minstret_q;
    ifu_req_valid = 1'b0;
    inst_we       = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    trap          = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_IF_REQ;
      S_IF_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready)  state_d = S_IF_WAIT;
        else if (tmo_exp)   state_d = S_TRAP;
      end
      // a handshake in the expiry cycle takes priority over the timeout
      S_IF_WAIT: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_TRAP;
          end else begin
            inst_we = 1'b1;
            state_d = S_EX;
          end
        end else if (tmo_exp) begin
          state_d = S_TRAP;
        end
      end
      S_EX: state_d = is_mem ? S_LS_REQ : S_WB;
      S_LS_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = dec_mem_write;
        if (lsu_req_ready)  state_d = S_LS_WAIT;
        else if (tmo_exp)   state_d = S_TRAP;
      end
      S_LS_WAIT: begin
        if (lsu_rsp_valid) begin
          state_d = lsu_rsp_err ? S_TRAP : S_WB;
        end else if (tmo_exp) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        pc_we      = 1'b1;
        rf_we      = dec_reg_write;
        csr_we     = csr_writes(dec_csr);
        minstret_d = minstret_q + COUNTER_W'(1);
        state_d    = S_IF_REQ;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      minstret_q <= minstret_d;
    end
  end

  assign minstret = minstret_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized bench for exec_sequencer: a procedural per-instruction model
// predicts every output each cycle; directed cases pin the model.
module tb_exec_sequencer;

  typedef struct {
    bit         rw;
    bit         mw;
    logic [2:0] ws;
    logic [2:0] cop;
    int         rd;
    int         wd;
    int         lrd;
    int         lwd;
    bit         ierr;
    bit         lerr;
    bit         abort;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       ifu_req_ready = 1'b0;
  logic       ifu_rsp_valid = 1'b0;
  logic       ifu_rsp_err = 1'b0;
  logic       dec_reg_write = 1'b0;
  logic       dec_mem_write = 1'b0;
  logic [2:0] dec_wd_src = 3'b0;
  logic [2:0] dec_csr = 3'b0;
  logic       lsu_req_ready = 1'b0;
  logic       lsu_rsp_valid = 1'b0;
  logic       lsu_rsp_err = 1'b0;

  logic rst_a, rst_b;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic        a_irv, a_iwe, a_lrv, a_lwen, a_pc, a_rf, a_csr, a_trap;
  logic        b_irv, b_iwe, b_lrv, b_lwen, b_pc, b_rf, b_csr, b_trap;
  logic [63:0] a_min, b_min;

  exec_sequencer #(.TIMEOUT_CYCLES(256), .COUNTER_W(64)) u_a (
    .clk(clk), .rst(rst_a),
    .ifu_req_valid(a_irv), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
    .inst_we(a_iwe),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_wd_src(dec_wd_src), .dec_csr(dec_csr),
    .lsu_req_valid(a_lrv), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(a_lwen),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .pc_we(a_pc), .rf_we(a_rf), .csr_we(a_csr),
    .trap(a_trap), .minstret(a_min)
  );

  exec_sequencer #(.TIMEOUT_CYCLES(8), .COUNTER_W(64)) u_b (
    .clk(clk), .rst(rst_b),
    .ifu_req_valid(b_irv), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
    .inst_we(b_iwe),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_wd_src(dec_wd_src), .dec_csr(dec_csr),
    .lsu_req_valid(b_lrv), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(b_lwen),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .pc_we(b_pc), .rf_we(b_rf), .csr_we(b_csr),
    .trap(b_trap), .minstret(b_min)
  );

  logic        m_irv, m_iwe, m_lrv, m_lwen, m_pc, m_rf, m_csr, m_trap;
  logic [63:0] m_min;
  assign m_irv  = sel ? b_irv  : a_irv;
  assign m_iwe  = sel ? b_iwe  : a_iwe;
  assign m_lrv  = sel ? b_lrv  : a_lrv;
  assign m_lwen = sel ? b_lwen : a_lwen;
  assign m_pc   = sel ? b_pc   : a_pc;
  assign m_rf   = sel ? b_rf   : a_rf;
  assign m_csr  = sel ? b_csr  : a_csr;
  assign m_trap = sel ? b_trap : a_trap;
  assign m_min  = sel ? b_min  : a_min;

  logic        e_irv, e_iwe, e_lrv, e_lwen, e_pc, e_rf, e_csr, e_trap;
  logic [63:0] e_min;
  logic [63:0] retired = 64'd0;
  bit          check_en = 1'b0;
  bit          lit_min_en = 1'b0;
  logic [63:0] lit_min_val = 64'd0;

  int n_chk = 0;
  int n_fail = 0;

  int       cyc = 0;
  int       n_rf = 0, n_pc = 0, n_all3 = 0;
  int       vrun = 0, last_run = 0;
  int       acc_cyc = 0, trap_cyc = 0;
  bit       trap_q = 1'b0;
  bit [7:0] wen_hist = 8'h0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      chk("ifu_req_valid", {63'd0, m_irv}, {63'd0, e_irv});
      chk("inst_we", {63'd0, m_iwe}, {63'd0, e_iwe});
      chk("lsu_req_valid", {63'd0, m_lrv}, {63'd0, e_lrv});
      chk("lsu_req_wen", {63'd0, m_lwen}, {63'd0, e_lwen});
      chk("pc_we", {63'd0, m_pc}, {63'd0, e_pc});
      chk("rf_we", {63'd0, m_rf}, {63'd0, e_rf});
      chk("csr_we", {63'd0, m_csr}, {63'd0, e_csr});
      chk("trap", {63'd0, m_trap}, {63'd0, e_trap});
      chk("minstret", m_min, e_min);
      if (m_rf === 1'b1) n_rf++;
      if (m_pc === 1'b1) n_pc++;
      if (m_rf === 1'b1 && m_csr === 1'b1 && m_pc === 1'b1) n_all3++;
      if (m_irv === 1'b1) begin
        vrun++;
        if (ifu_req_ready) begin
          last_run = vrun;
          vrun = 0;
          acc_cyc = cyc + 1;
        end
      end else begin
        vrun = 0;
      end
      if (m_lrv === 1'b1 && lsu_req_ready)
        wen_hist = {wen_hist[6:0], m_lwen};
      if (m_trap === 1'b1 && !trap_q) trap_cyc = cyc;
      trap_q = (m_trap === 1'b1);
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
    ifu_req_ready = 1'($urandom_range(0, 1));
    ifu_rsp_valid = ($urandom_range(0, 3) == 0);
    ifu_rsp_err   = 1'($urandom_range(0, 1));
    lsu_req_ready = 1'($urandom_range(0, 1));
    lsu_rsp_valid = ($urandom_range(0, 3) == 0);
    lsu_rsp_err   = 1'($urandom_range(0, 1));
    e_irv = 0; e_iwe = 0; e_lrv = 0; e_lwen = 0;
    e_pc = 0; e_rf = 0; e_csr = 0; e_trap = 0;
    e_min = retired;
  endtask

  task automatic rand_dec();
    dec_reg_write = 1'($urandom);
    dec_mem_write = 1'($urandom);
    dec_wd_src    = 3'($urandom);
    dec_csr       = 3'($urandom);
  endtask

  task automatic lit_sync();
    @(negedge clk);
    #1;
  endtask

  // caller has already advanced into the cycle where reset asserts
  task automatic rst_tail();
    check_en = 1'b1;
    rst = 1'b1;
    retired = 64'd0;
    e_min = 64'd0;
    lsu_rsp_valid = 1'b1;
    ifu_rsp_valid = 1'b1;
    nc();
    rst = 1'b1;
    lsu_rsp_valid = 1'b1;
    ifu_rsp_valid = 1'b1;
    nc();
    rst = 1'b0;
    lsu_rsp_valid = 1'b1;
    lsu_rsp_err = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_err = 1'b0;
  endtask

  task automatic do_reset(input bit s);
    nc();
    sel = s;
    rst_tail();
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      nc();
      rand_dec();
      e_trap = 1'b1;
    end
  endtask

  function automatic instr_t ins(input bit rw, input bit mw,
                                 input logic [2:0] ws, input logic [2:0] cop);
    instr_t t;
    t.rw = rw; t.mw = mw; t.ws = ws; t.cop = cop;
    t.rd = 0; t.wd = 0; t.lrd = 0; t.lwd = 0;
    t.ierr = 0; t.lerr = 0; t.abort = 0;
    return t;
  endfunction

  // walks one instruction phase by phase, setting inputs and expectations
  task automatic run_instr(input instr_t t, output bit trapped,
                           output bit aborted);
    bit ok;
    int tmo;
    tmo = sel ? 8 : 256;
    trapped = 0;
    aborted = 0;
    ok = 0;
    for (int k = 0; k < tmo && !ok; k++) begin
      nc();
      rand_dec();
      e_irv = 1'b1;
      ifu_req_ready = (k == t.rd);
      if (k == t.rd) ok = 1;
      if (k == 0 && lit_min_en) begin
        lit_sync();
        chk("minstret_literal", m_min, lit_min_val);
        lit_min_en = 1'b0;
      end
    end
    if (!ok) begin trapped = 1; return; end
    ok = 0;
    for (int k = 0; k < tmo && !ok; k++) begin
      nc();
      rand_dec();
      ifu_rsp_valid = (k == t.wd);
      ifu_rsp_err = t.ierr;
      if (k == t.wd) begin
        if (t.ierr) begin trapped = 1; return; end
        e_iwe = 1'b1;
        ok = 1;
      end
    end
    if (!ok) begin trapped = 1; return; end
    nc();
    dec_reg_write = t.rw;
    dec_mem_write = t.mw;
    dec_wd_src = t.ws;
    dec_csr = t.cop;
    if (t.mw || t.ws == 3'b100) begin
      ok = 0;
      for (int k = 0; k < tmo && !ok; k++) begin
        nc();
        e_lrv = 1'b1;
        e_lwen = t.mw;
        lsu_req_ready = (k == t.lrd);
        if (k == t.lrd) ok = 1;
      end
      if (!ok) begin trapped = 1; return; end
      ok = 0;
      for (int k = 0; k < tmo && !ok; k++) begin
        nc();
        if (t.abort) begin
          rst_tail();
          aborted = 1;
          return;
        end
        lsu_rsp_valid = (k == t.lwd);
        lsu_rsp_err = t.lerr;
        if (k == t.lwd) begin
          if (t.lerr) begin trapped = 1; return; end
          ok = 1;
        end
      end
      if (!ok) begin trapped = 1; return; end
    end
    nc();
    e_pc = 1'b1;
    e_rf = t.rw;
    e_csr = t.cop inside {3'b010, 3'b011, 3'b101, 3'b110};
    retired = retired + 64'd1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    bit tr, ab;
    int p_rf, p_pc, p_all3;

    do_reset(1'b0);
    lit_sync();
    chk("reset_minstret", m_min, 64'd0);
    chk("reset_trap", {63'd0, m_trap}, 64'd0);

    p_rf = n_rf;
    run_instr(ins(1, 0, 3'b000, 3'b000), tr, ab);
    run_instr(ins(1, 0, 3'b100, 3'b000), tr, ab);
    run_instr(ins(0, 1, 3'b001, 3'b000), tr, ab);
    lit_sync();
    chk("rf_pulses_addi_lw_sw", 64'(n_rf - p_rf), 64'd2);
    chk("lsu_wen_lw_then_sw", {62'd0, wen_hist[1:0]}, 64'd1);
    lit_min_en = 1'b1;
    lit_min_val = 64'd3;

    p_pc = n_pc;
    t = ins(1, 0, 3'b000, 3'b000);
    t.rd = 10;
    run_instr(t, tr, ab);
    lit_sync();
    chk("ifu_accept_cycle", 64'(last_run), 64'd11);
    chk("stall_retire", 64'(n_pc - p_pc), 64'd1);

    p_rf = n_rf;
    p_pc = n_pc;
    t = ins(1, 0, 3'b100, 3'b000);
    t.lerr = 1;
    run_instr(t, tr, ab);
    trap_hold(5);
    lit_sync();
    chk("lsu_err_trap", {63'd0, m_trap}, 64'd1);
    chk("lsu_err_no_rf", 64'(n_rf - p_rf), 64'd0);
    chk("lsu_err_no_pc", 64'(n_pc - p_pc), 64'd0);

    do_reset(1'b1);
    t = ins(1, 0, 3'b000, 3'b000);
    t.wd = 99;
    run_instr(t, tr, ab);
    trap_hold(2);
    lit_sync();
    chk("timeout_latency", 64'(trap_cyc - acc_cyc), 64'd8);

    do_reset(1'b1);
    p_pc = n_pc;
    t = ins(1, 0, 3'b000, 3'b000);
    t.wd = 7;
    run_instr(t, tr, ab);
    lit_sync();
    chk("rsp_in_expiry_cycle", 64'(n_pc - p_pc), 64'd1);

    p_all3 = n_all3;
    run_instr(ins(1, 0, 3'b011, 3'b110), tr, ab);
    lit_sync();
    chk("csrrs_all_strobes", 64'(n_all3 - p_all3), 64'd1);

    p_pc = n_pc;
    t = ins(1, 0, 3'b100, 3'b000);
    t.abort = 1;
    run_instr(t, tr, ab);
    lit_sync();
    chk("abort_minstret", m_min, 64'd0);
    chk("abort_no_pc", 64'(n_pc - p_pc), 64'd0);
    run_instr(ins(0, 0, 3'b000, 3'b011), tr, ab);

    do_reset(1'($urandom));
    for (int n = 0; n < 250; n++) begin
      t = ins(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
      t.rd  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 11))
                                            : int'($urandom_range(0, 3));
      t.wd  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 11))
                                            : int'($urandom_range(0, 3));
      t.lrd = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 11))
                                            : int'($urandom_range(0, 3));
      t.lwd = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 11))
                                            : int'($urandom_range(0, 3));
      t.ierr  = ($urandom_range(0, 19) == 0);
      t.lerr  = ($urandom_range(0, 19) == 0);
      t.abort = ($urandom_range(0, 29) == 0);
      run_instr(t, tr, ab);
      if (tr) begin
        trap_hold(int'($urandom_range(1, 4)));
        do_reset(1'($urandom));
      end
    end
    lit_sync();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
